// File: rtl/t21_prog_loader.sv
// t21_prog_loader: boot-time program loader and run sequencer for a t21_node array.
// Accepts a valid/ready stream of load frames, holds every node in reset while
// loading, writes each frame's instruction words into the selected node's
// instruction memory through a one-hot write strobe, and releases the nodes
// once a terminator frame (id 8'hFF) is accepted.
//
// Frame: header word (id = in_data[INSTR_W-1 -: 8], cnt = in_data[ADDR_W:0])
// followed by cnt instruction words.
//
// Optional build macro T21_LOADER_CHECKSUM_EN: each non-terminator frame carries
// one extra trailing word equal to the XOR of its instruction words. The word is
// never written; a mismatch sends the loader to ERROR.
//
// INSTR_W must be >= 16 and >= ADDR_W+9 so the id and cnt fields do not overlap.
module t21_prog_loader #(
  parameter int NUM_NODES = 2,
  parameter int ADDR_W    = 4,
  parameter int INSTR_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [INSTR_W-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_NODES-1:0] write_en,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [INSTR_W-1:0]   write_data,
  output logic                 node_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // Terminator id and the largest legal word count (one full memory).
  localparam logic [7:0]      TERM_ID  = 8'hFF;
  localparam logic [ADDR_W:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_LAST = {{ADDR_W{1'b0}}, 1'b1};

  // ST_CKSUM is only reachable when the checksum word is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_CKSUM  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t state;

  // Context of the frame currently being loaded.
  logic [7:0]        node_sel;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   rem_cnt;
`ifdef T21_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] csum_acc;
`endif

  // Header decode, only meaningful while in ST_HEADER.
  logic [7:0]      hdr_id;
  logic [ADDR_W:0] hdr_cnt;
  logic            hdr_bad;
  logic            xfer;

  assign hdr_id  = in_data[INSTR_W-1 -: 8];
  assign hdr_cnt = in_data[ADDR_W:0];
  assign hdr_bad = (int'(hdr_id) >= NUM_NODES) || (hdr_cnt == '0) || (hdr_cnt > CNT_MAX);
  // in_ready is registered from state alone, so this is a clean handshake.
  assign xfer    = in_valid && in_ready;

  // One-hot write strobe for the selected node.
  function automatic logic [NUM_NODES-1:0] node_onehot(input logic [7:0] id);
    logic [NUM_NODES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (int'(id) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Load sequencer: state, frame context and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      write_en   <= '0;
      write_addr <= '0;
      write_data <= '0;
      node_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      node_sel   <= '0;
      addr_cnt   <= '0;
      rem_cnt    <= '0;
`ifdef T21_LOADER_CHECKSUM_EN
      csum_acc   <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless re-armed below.
      write_en <= '0;
      done     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_HEADER;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            node_reset <= 1'b1;
            error      <= 1'b0;
          end
        end

        ST_HEADER: begin
          if (xfer) begin
            if (hdr_id == TERM_ID) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (hdr_bad) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state    <= ST_DATA;
              node_sel <= hdr_id;
              rem_cnt  <= hdr_cnt;
              addr_cnt <= '0;
`ifdef T21_LOADER_CHECKSUM_EN
              csum_acc <= '0;
`endif
            end
          end
        end

        // ---- write stage: handshake here, strobe appears next cycle ----
        ST_DATA: begin
          if (xfer) begin
            write_en   <= node_onehot(node_sel);
            write_addr <= addr_cnt;
            write_data <= in_data;
            addr_cnt   <= addr_cnt + 1'b1;
            rem_cnt    <= rem_cnt - 1'b1;
`ifdef T21_LOADER_CHECKSUM_EN
            csum_acc   <= csum_acc ^ in_data;
            if (rem_cnt == CNT_LAST) state <= ST_CKSUM;
`else
            if (rem_cnt == CNT_LAST) state <= ST_HEADER;
`endif
          end
        end

`ifdef T21_LOADER_CHECKSUM_EN
        // Trailing checksum word: compared, never written.
        ST_CKSUM: begin
          if (xfer) begin
            if (in_data == csum_acc) begin
              state <= ST_HEADER;
            end else begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end
          end
        end
`endif

        // done is high for exactly this cycle; nodes run from the next one.
        ST_DONE: begin
          state      <= ST_IDLE;
          node_reset <= 1'b0;
        end

        // Sticky until a new session is started; nodes stay in reset.
        ST_ERROR: begin
          if (start) begin
            state      <= ST_HEADER;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            node_reset <= 1'b1;
            error      <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
